ps2_host_tx: RTL

- PS/2 host-to-device transmitter; the opposite direction of the keyboard receive path.
- Sends one command byte to the keyboard (e.g. 0xED set-LEDs, 0xFF reset) over the shared PS2_CLOCK/PS2_DATA lines using open-drain enables.
- Runs on the 33.33 MHz system clock.
- While a transfer is in progress, the top level gates the receiver with busy.

---
 rtl/ps2_host_tx.sv | 195 +++++++++++++++++++
 1 files changed

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device command transmitter: inhibits the bus, requests to send, then shifts one
// byte out on device clock edges. Optional auto-retry is built when PS2_TX_AUTO_RETRY_EN is defined.
//
// state      | meaning
// IDLE       | lines released, ready for a byte
// INHIBIT    | clock held low for INHIBIT_CYCLES
// RTS        | clock and data low for one cycle (start bit)
// WAIT_CLK   | clock released, waiting for the first device falling edge
// SEND       | bits 0..7, parity, stop presented on successive falls
// ACK        | check the data level sampled on the 11th fall
// WAIT_IDLE  | wait for the bus to return to idle (both lines high)
// DONE       | tx_done pulse
// ERROR      | tx_error pulse, lines released
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES       = 3334,
  parameter int START_TIMEOUT_CYCLES = 500000,
  parameter int FRAME_TIMEOUT_CYCLES = 66667,
  parameter int MAX_RETRIES          = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  input  logic       ps2_clk_in,
  input  logic       ps2_data_in,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe,
  output logic       busy,
  output logic       tx_done,
  output logic       tx_error
);

  typedef enum logic [3:0] {
    S_IDLE, S_INHIBIT, S_RTS, S_WAIT_CLK, S_SEND, S_ACK, S_WAIT_IDLE, S_DONE, S_ERROR
  } state_t;

  localparam logic [18:0] INH_LAST  = 19'(INHIBIT_CYCLES - 1);
  localparam logic [18:0] START_LIM = 19'(START_TIMEOUT_CYCLES);
  localparam logic [18:0] FRAME_LIM = 19'(FRAME_TIMEOUT_CYCLES);
`ifdef PS2_TX_AUTO_RETRY_EN
  localparam bit RETRY_EN = 1'b1;
`else
  localparam bit RETRY_EN = 1'b0;
`endif

  state_t      state;
  logic [18:0] timer;
  logic [7:0]  tx_byte;
  logic        parity;
  logic [3:0]  idx;
  logic        ack_bit;
  logic [3:0]  retry_cnt;

  logic clk_s1, clk_s2, clk_prev;
  logic data_s1, data_s2;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clk_s1   <= 1'b1;
      clk_s2   <= 1'b1;
      clk_prev <= 1'b1;
      data_s1  <= 1'b1;
      data_s2  <= 1'b1;
    end else begin
      clk_s1   <= ps2_clk_in;
      clk_s2   <= clk_s1;
      clk_prev <= clk_s2;
      data_s1  <= ps2_data_in;
      data_s2  <= data_s1;
    end
  end

  logic       fall;
  logic       fail;
  logic       can_retry;
  logic [3:0] next_idx;
  logic       next_oe;

  always_comb begin
    fall      = clk_prev & ~clk_s2;
    can_retry = RETRY_EN && (int'(retry_cnt) < MAX_RETRIES);
    fail      = 1'b0;
    if (state == S_WAIT_CLK && timer >= START_LIM)
      fail = 1'b1;
    if ((state == S_SEND || state == S_ACK || state == S_WAIT_IDLE) && timer >= FRAME_LIM)
      fail = 1'b1;
    if (state == S_ACK && ack_bit)
      fail = 1'b1;
    next_idx = idx + 4'd1;
    next_oe  = 1'b0;
    // Open-drain: a 0 bit is driven low, a 1 bit (and the stop bit) is released.
    if (next_idx <= 4'd7)
      next_oe = ~tx_byte[next_idx[2:0]];
    else if (next_idx == 4'd8)
      next_oe = ~parity;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      timer       <= '0;
      tx_byte     <= '0;
      parity      <= 1'b0;
      idx         <= '0;
      ack_bit     <= 1'b1;
      retry_cnt   <= '0;
      ps2_clk_oe  <= 1'b0;
      ps2_data_oe <= 1'b0;
      tx_ready    <= 1'b1;
      busy        <= 1'b0;
      tx_done     <= 1'b0;
      tx_error    <= 1'b0;
    end else begin
      tx_done  <= 1'b0;
      tx_error <= 1'b0;
      if (timer != '1)
        timer <= timer + 19'd1;

      if (fail) begin
        if (can_retry) begin
          retry_cnt   <= retry_cnt + 4'd1;
          timer       <= '0;
          ps2_clk_oe  <= 1'b1;
          ps2_data_oe <= 1'b0;
          state       <= S_INHIBIT;
        end else begin
          ps2_clk_oe  <= 1'b0;
          ps2_data_oe <= 1'b0;
          tx_error    <= 1'b1;
          state       <= S_ERROR;
        end
      end else begin
        case (state)
          S_IDLE: begin
            if (tx_valid) begin
              tx_byte    <= tx_data;
              parity     <= ~^tx_data;
              retry_cnt  <= '0;
              timer      <= '0;
              ps2_clk_oe <= 1'b1;
              tx_ready   <= 1'b0;
              busy       <= 1'b1;
              state      <= S_INHIBIT;
            end
          end
          S_INHIBIT: begin
            if (timer == INH_LAST) begin
              ps2_data_oe <= 1'b1;
              state       <= S_RTS;
            end
          end
          S_RTS: begin
            ps2_clk_oe <= 1'b0;
            timer      <= '0;
            state      <= S_WAIT_CLK;
          end
          S_WAIT_CLK: begin
            if (fall) begin
              idx         <= '0;
              ps2_data_oe <= ~tx_byte[0];
              timer       <= '0;
              state       <= S_SEND;
            end
          end
          S_SEND: begin
            if (fall) begin
              if (idx == 4'd9) begin
                ack_bit <= data_s2;
                state   <= S_ACK;
              end else begin
                idx         <= next_idx;
                ps2_data_oe <= next_oe;
              end
            end
          end
          S_ACK: state <= S_WAIT_IDLE;
          S_WAIT_IDLE: begin
            if (clk_s2 && data_s2) begin
              tx_done <= 1'b1;
              state   <= S_DONE;
            end
          end
          S_DONE, S_ERROR: begin
            tx_ready <= 1'b1;
            busy     <= 1'b0;
            state    <= S_IDLE;
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule
